gfx_pattern_gen: RTL and testbench

GFX_PATTERN_GEN -- requirements
Module: gfx_pattern_gen

---
 rtl/gfx_pattern_pkg.sv | 18 +
 rtl/gfx_pattern_color.sv | 73 +++++++
 rtl/gfx_pattern_gen.sv | 137 +++++++++++++
 tb/tb_gfx_pattern_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pattern_pkg.sv
// Shared types for the test-pattern generator: pattern encodings and FSM states.
// No logic, no latency.
// No flow control here; consumers own the valid/ready handshake.
package gfx_pattern_pkg;

   typedef enum logic [1:0] {
      PATTERN_VBARS    = 2'd0,
      PATTERN_HBARS    = 2'd1,
      PATTERN_CHECKER  = 2'd2,
      PATTERN_GRADIENT = 2'd3
   } pattern_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/gfx_pattern_color.sv
// Maps a pattern mode and a pixel coordinate to a packed {red, grn, blu} color.
// Purely combinational, zero latency; the parent registers the result with the coordinate.
// No backpressure: the parent only feeds it the coordinate that will be presented next.
module gfx_pattern_color
   import gfx_pattern_pkg::*;
#(
   parameter int FB_WIDTH    = 640,
   parameter int FB_HEIGHT   = 480,
   parameter int PIXEL_BITS  = 12,
   parameter int CHECK_SHIFT = 4,
   parameter int XW          = 10,
   parameter int YW          = 9
) (
   input  logic [1:0]            mode,
   input  logic [XW-1:0]         x,
   input  logic [YW-1:0]         y,
   output logic [PIXEL_BITS-1:0] color
);

   localparam int CB = PIXEL_BITS / 3;
   localparam int unsigned W3 = FB_WIDTH / 3;
   localparam int unsigned H3 = FB_HEIGHT / 3;
   localparam logic [CB-1:0] FULL = {CB{1'b1}};

   // Widen coordinates so thresholds and narrow gradient channels compare/extend cleanly
   logic [31:0] xe;
   logic [31:0] ye;
   assign xe = 32'(x);
   assign ye = 32'(y);

   logic [CB-1:0] red;
   logic [CB-1:0] grn;
   logic [CB-1:0] blu;

   // Per-channel pattern selection; channels not lit by a pattern stay at zero
   always_comb begin
      red = '0;
      grn = '0;
      blu = '0;
      case (mode)
         PATTERN_VBARS: begin
            if (xe < W3)          red = FULL;
            else if (xe < 2 * W3) grn = FULL;
            else                  blu = FULL;
         end
         PATTERN_HBARS: begin
            if (ye < H3)          red = FULL;
            else if (ye < 2 * H3) grn = FULL;
            else                  blu = FULL;
         end
         PATTERN_CHECKER: begin
            // Cell parity is the xor of the coordinate bits just above the cell size
            if ((xe[CHECK_SHIFT] ^ ye[CHECK_SHIFT]) == 1'b0) begin
               red = FULL;
               grn = FULL;
               blu = FULL;
            end
         end
         PATTERN_GRADIENT: begin
            red = xe[CB-1:0];
            grn = ye[CB-1:0];
            // Low bits of a sum depend only on the low bits of the operands
            blu = xe[CB-1:0] + ye[CB-1:0];
         end
         default: begin
            red = '0;
         end
      endcase
   end

   assign color = PIXEL_BITS'({red, grn, blu});

endmodule

// File: rtl/gfx_pattern_gen.sv
// Raster-scan test-pattern source: one pixel per cycle, frames started by start, optional looping.
// First pixel one cycle after start; next pixel the cycle after each transfer (no bubbles).
// Holds x/y/color/last stable while valid && !ready; mode/loop only change at frame boundaries.
`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif

module gfx_pattern_gen
   import gfx_pattern_pkg::*;
#(
   parameter int FB_WIDTH    = `VGA_MODE_H_VISIBLE,
   parameter int FB_HEIGHT   = `VGA_MODE_V_VISIBLE,
   parameter int PIXEL_BITS  = 12,
   parameter int CHECK_SHIFT = 4,
   localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1,
   localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  loop,
   input  logic                  ready,
   output logic                  valid,
   output logic [XW-1:0]         x,
   output logic [YW-1:0]         y,
   output logic [PIXEL_BITS-1:0] color,
   output logic                  last,
   output logic                  busy
);

   localparam logic [XW-1:0] X_MAX = XW'(FB_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(FB_HEIGHT - 1);

   state_e        state;
   logic [1:0]    mode_q;
   logic          loop_q;

   logic [XW-1:0]         nxt_x;
   logic [YW-1:0]         nxt_y;
   logic [1:0]            nxt_mode;
   logic [PIXEL_BITS-1:0] nxt_color;
   logic                  nxt_last;

   // Coordinate and mode of the pixel to present after the next transfer (or after start);
   // a new frame always begins at (0,0) using the live mode input, which is latched alongside
   always_comb begin
      nxt_x    = '0;
      nxt_y    = '0;
      nxt_mode = mode;
      if (state == ST_RUN && !last) begin
         nxt_mode = mode_q;
         if (x == X_MAX) begin
            nxt_y = y + YW'(1);
         end else begin
            nxt_x = x + XW'(1);
            nxt_y = y;
         end
      end
   end

   assign nxt_last = (nxt_x == X_MAX) && (nxt_y == Y_MAX);

   gfx_pattern_color #(
      .FB_WIDTH    (FB_WIDTH),
      .FB_HEIGHT   (FB_HEIGHT),
      .PIXEL_BITS  (PIXEL_BITS),
      .CHECK_SHIFT (CHECK_SHIFT),
      .XW          (XW),
      .YW          (YW)
   ) u_color (
      .mode  (nxt_mode),
      .x     (nxt_x),
      .y     (nxt_y),
      .color (nxt_color)
   );

   // Frame FSM; pixel outputs are registered together so color always matches x/y
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         mode_q <= 2'd0;
         loop_q <= 1'b0;
         valid  <= 1'b0;
         x      <= '0;
         y      <= '0;
         color  <= '0;
         last   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_RUN;
                  mode_q <= mode;
                  loop_q <= loop;
                  valid  <= 1'b1;
                  x      <= nxt_x;
                  y      <= nxt_y;
                  color  <= nxt_color;
                  last   <= nxt_last;
               end
            end
            ST_RUN: begin
               if (valid && ready) begin
                  if (last && !loop_q) begin
                     state <= ST_IDLE;
                     valid <= 1'b0;
                     x     <= '0;
                     y     <= '0;
                     color <= '0;
                     last  <= 1'b0;
                  end else begin
                     if (last) begin
                        mode_q <= mode;
                        loop_q <= loop;
                     end
                     x     <= nxt_x;
                     y     <= nxt_y;
                     color <= nxt_color;
                     last  <= nxt_last;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_gfx_pattern_gen.sv
module tb_gfx_pattern_gen;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic        loop;
   logic        ready;
   logic        valid;
   logic [2:0]  x;
   logic [1:0]  y;
   logic [11:0] color;
   logic        last;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // capture results
   int          px_x [0:127];
   int          px_y [0:127];
   logic [11:0] px_c [0:127];
   logic        px_l [0:127];
   int          cnt;
   int          cyc;

   // mid-capture stimulus knobs
   int          sw_at      = -1;
   logic [1:0]  sw_mode    = 2'd0;
   logic        sw_loop    = 1'b0;
   bit          poke_start = 1'b0;

   gfx_pattern_gen #(
      .FB_WIDTH    (8),
      .FB_HEIGHT   (4),
      .PIXEL_BITS  (12),
      .CHECK_SHIFT (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .loop  (loop),
      .ready (ready),
      .valid (valid),
      .x     (x),
      .y     (y),
      .color (color),
      .last  (last),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference colors for an 8x4 frame, 12-bit pixels, 2-pixel checker cells
   function automatic logic [11:0] ref_color(input logic [1:0] m, input int px, input int py);
      logic [3:0] s;
      s = 4'(px + py);
      case (m)
         2'd0:    ref_color = (px < 2) ? 12'hF00 : (px < 4) ? 12'h0F0 : 12'h00F;
         2'd1:    ref_color = (py < 1) ? 12'hF00 : (py < 2) ? 12'h0F0 : 12'h00F;
         2'd2:    ref_color = ((((px >> 1) ^ (py >> 1)) & 1) != 0) ? 12'h000 : 12'hFFF;
         default: ref_color = {4'(px), 4'(py), s};
      endcase
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("first_vld", 32'(valid), 32'd1);
   endtask

   // Collect n transfers; ready follows rpat[cyc%4]; checks outputs hold during stalls
   task automatic capture(input int n, input logic [3:0] rpat);
      logic        hold_pend;
      int          hx, hy;
      logic [11:0] hc;
      logic        hl;
      hold_pend = 1'b0;
      hx = 0; hy = 0; hc = '0; hl = 1'b0;
      cnt = 0;
      cyc = 0;
      while (cnt < n && cyc < 1000) begin
         ready = rpat[cyc % 4];
         start = poke_start && (cyc % 5 == 2);
         if (hold_pend) begin
            chk($sformatf("hold_x_c%0d", cyc), 32'(x), 32'(hx));
            chk($sformatf("hold_y_c%0d", cyc), 32'(y), 32'(hy));
            chk($sformatf("hold_col_c%0d", cyc), 32'(color), 32'(hc));
            chk($sformatf("hold_lst_c%0d", cyc), 32'(last), 32'(hl));
            chk($sformatf("hold_vld_c%0d", cyc), 32'(valid), 32'd1);
            hold_pend = 1'b0;
         end
         if (valid && ready) begin
            px_x[cnt] = int'(x);
            px_y[cnt] = int'(y);
            px_c[cnt] = color;
            px_l[cnt] = last;
            cnt++;
            if (cnt == sw_at) begin
               mode = sw_mode;
               loop = sw_loop;
            end
         end else if (valid) begin
            hx = int'(x); hy = int'(y); hc = color; hl = last;
            hold_pend = 1'b1;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      chk("xfer_count", 32'(cnt), 32'(n));
   endtask

   // Frame 0 uses m0, later frames m1
   task automatic verify(input string tag, input int n, input logic [1:0] m0, input logic [1:0] m1);
      for (int i = 0; i < n; i++) begin
         int ex, ey;
         logic [1:0] m;
         ex = i % 8;
         ey = (i / 8) % 4;
         m  = (i < 32) ? m0 : m1;
         chk($sformatf("%s_x%0d", tag, i), 32'(px_x[i]), 32'(ex));
         chk($sformatf("%s_y%0d", tag, i), 32'(px_y[i]), 32'(ey));
         chk($sformatf("%s_c%0d", tag, i), 32'(px_c[i]), 32'(ref_color(m, ex, ey)));
         chk($sformatf("%s_l%0d", tag, i), 32'(px_l[i]), 32'((i % 32) == 31));
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_vld"}, 32'(valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 2'd0;
      loop  = 1'b0;
      ready = 1'b0;
      step(); step(); step();
      reset = 1'b0;

      // reset state
      chk("rst_vld",  32'(valid), 32'd0);
      chk("rst_busy", 32'(busy),  32'd0);
      chk("rst_lst",  32'(last),  32'd0);
      chk("rst_x",    32'(x),     32'd0);
      chk("rst_y",    32'(y),     32'd0);
      chk("rst_col",  32'(color), 32'd0);

      // mode 0, full throughput, single frame
      mode = 2'd0; loop = 1'b0;
      pulse_start();
      chk("m0_busy", 32'(busy), 32'd1);
      capture(32, 4'b1111);
      chk("m0_tput", 32'(cyc), 32'd32);
      chk_idle("m0_end");
      verify("m0", 32, 2'd0, 2'd0);
      chk("m0_c_x0", 32'(px_c[0]), 32'h0F00);
      chk("m0_c_x2", 32'(px_c[2]), 32'h00F0);
      chk("m0_c_x7", 32'(px_c[7]), 32'h000F);
      chk("m0_last31", 32'(px_l[31]), 32'd1);
      chk("m0_last30", 32'(px_l[30]), 32'd0);

      // mode 0 with ready 1,0,0,1
      step();
      pulse_start();
      capture(32, 4'b1001);
      chk_idle("bp_end");
      verify("bp", 32, 2'd0, 2'd0);

      // checkerboard
      mode = 2'd2;
      pulse_start();
      capture(32, 4'b1111);
      chk_idle("ck_end");
      verify("ck", 32, 2'd2, 2'd2);
      chk("ck_0_0", 32'(px_c[0]),  32'h0FFF);
      chk("ck_2_0", 32'(px_c[2]),  32'h0000);
      chk("ck_2_2", 32'(px_c[18]), 32'h0FFF);

      // gradient
      mode = 2'd3;
      pulse_start();
      capture(32, 4'b1111);
      chk_idle("gr_end");
      verify("gr", 32, 2'd3, 2'd3);
      chk("gr_5_2", 32'(px_c[21]), 32'h0527);

      // looping; mode -> 1 and loop -> 0 at pixel 10 take effect only at next frame
      mode = 2'd0; loop = 1'b1;
      sw_at = 10; sw_mode = 2'd1; sw_loop = 1'b0;
      pulse_start();
      capture(64, 4'b1111);
      sw_at = -1;
      chk("lp_nogap", 32'(cyc), 32'd64);
      chk_idle("lp_end");
      verify("lp", 64, 2'd0, 2'd1);
      chk("lp_f2_0_0", 32'(px_c[32]), 32'h0F00);
      chk("lp_f2_0_3", 32'(px_c[56]), 32'h000F);

      // reset mid-frame at pixel 13, start during reset ignored
      mode = 2'd0; loop = 1'b0;
      pulse_start();
      capture(13, 4'b1111);
      chk("rm_pre_x", 32'(x), 32'd5);
      reset = 1'b1;
      start = 1'b1;
      ready = 1'b1;
      step();
      chk("rm_vld",  32'(valid), 32'd0);
      chk("rm_busy", 32'(busy),  32'd0);
      chk("rm_x",    32'(x),     32'd0);
      chk("rm_y",    32'(y),     32'd0);
      chk("rm_col",  32'(color), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      step();
      chk_idle("rm_post");
      mode = 2'd3;
      pulse_start();
      capture(32, 4'b1111);
      chk_idle("rm_new_end");
      verify("rm_new", 32, 2'd3, 2'd3);

      // start pulses while busy are ignored
      mode = 2'd1; loop = 1'b0;
      poke_start = 1'b1;
      pulse_start();
      capture(32, 4'b1111);
      poke_start = 1'b0;
      chk_idle("ign_end");
      verify("ign", 32, 2'd1, 2'd1);
      step(); step(); step();
      chk_idle("ign_stay");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
